// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: single-chip-select SPI master, mode 0 (CPOL=0, CPHA=0).
// Sends bc+1 bytes (8..64 bits) from a right-aligned transmit word and returns
// the received bits right-aligned, with a one-cycle read strobe at the end.
// SCK timing comes entirely from the external half-period tick.
// Build option: define SPI_MASTER_LSB_FIRST_EN for LSB-first bit order
// (default is MSB-first).
module spi_master_ctrl #(
    parameter int HOLD_TICKS = 1    // ticks from last SCK fall to CS_n rise, 1..15
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        reg_ctrl_tran,
    input  logic [2:0]  reg_ctrl_bc,
    input  logic [63:0] reg_ctrl_tx_data,
    input  logic        reg_ctrl_oe,
    input  logic        clkgen_ctrl_tick,
    input  logic        spi_miso,
    output logic        ctrl_reg_busy,
    output logic [63:0] ctrl_reg_rx_data,
    output logic        ctrl_reg_rd_en,
    output logic        spi_sck,
    output logic        spi_mosi,
    output logic        spi_cs_n,
    output logic        spi_oe
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [2:0]  r_bc;          // byte count minus one, latched at start
    logic [63:0] r_tx;          // transmit word, latched at start
    logic [63:0] r_rx;          // receive assembly register
    logic [5:0]  r_bit_cnt;     // bits still to send after the current one
    logic [3:0]  r_hold_cnt;    // ticks spent in HOLD
    logic        r_sck;
    logic        r_mosi;
    logic        r_cs_n;
    logic        r_oe;
    logic [63:0] r_rx_data;
    logic        r_rd_en;

    logic [5:0]  w_start_last;  // index of the last bit for the requested length
    logic [5:0]  w_cnt_dec;
    logic        w_hold_last;
    logic [63:0] w_rx_mask;     // ones over the bits actually transferred
    logic [5:0]  w_tx_first_idx;
    logic [5:0]  w_tx_next_idx;
    logic [5:0]  w_rx_idx;

    assign w_start_last = {reg_ctrl_bc, 3'b111};
    assign w_cnt_dec    = r_bit_cnt - 6'd1;
    assign w_hold_last  = (r_hold_cnt == 4'(HOLD_TICKS - 1));
    assign w_rx_mask    = 64'hFFFF_FFFF_FFFF_FFFF >> {~r_bc, 3'b000};

    // The bit counter runs from last-bit index down to 0 in both orders; only
    // the mapping from counter to word position depends on bit order.
`ifdef SPI_MASTER_LSB_FIRST_EN
    logic [5:0] w_last;
    assign w_last         = {r_bc, 3'b111};
    assign w_tx_first_idx = 6'd0;
    assign w_tx_next_idx  = w_last - w_cnt_dec;
    assign w_rx_idx       = w_last - r_bit_cnt;
`else
    assign w_tx_first_idx = w_start_last;
    assign w_tx_next_idx  = w_cnt_dec;
    assign w_rx_idx       = r_bit_cnt;
`endif

    // State register.
    // NOTE: every flop uses non-blocking (<=) so all registers see pre-edge values.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; without a tick nothing but IDLE/DONE can advance.
    always_comb begin
        // NOTE: default first so no path leaves w_state_next unassigned (no latch).
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (reg_ctrl_tran)    w_state_next = ST_SETUP;
            ST_SETUP: if (clkgen_ctrl_tick) w_state_next = ST_SHIFT;
            ST_SHIFT: if (clkgen_ctrl_tick && r_sck && (r_bit_cnt == 6'd0))
                                            w_state_next = ST_HOLD;
            ST_HOLD:  if (clkgen_ctrl_tick && w_hold_last)
                                            w_state_next = ST_DONE;
            ST_DONE:                        w_state_next = ST_IDLE;
            default:                        w_state_next = ST_IDLE;
        endcase
    end

    // Datapath and pin registers, stepped in lockstep with the state decode.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            // NOTE: data registers are reset as well: an aborted transfer must leave rx data at 0.
            r_bc       <= 3'd0;
            r_tx       <= 64'd0;
            r_rx       <= 64'd0;
            r_bit_cnt  <= 6'd0;
            r_hold_cnt <= 4'd0;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_oe       <= 1'b0;
            r_rx_data  <= 64'd0;
            r_rd_en    <= 1'b0;
        end else begin
            r_oe    <= reg_ctrl_oe;
            r_rd_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_sck  <= 1'b0;
                    r_mosi <= 1'b0;
                    r_cs_n <= 1'b1;
                    if (reg_ctrl_tran) begin
                        r_bc       <= reg_ctrl_bc;
                        r_tx       <= reg_ctrl_tx_data;
                        r_bit_cnt  <= w_start_last;
                        r_hold_cnt <= 4'd0;
                        r_cs_n     <= 1'b0;
                        r_mosi     <= reg_ctrl_tx_data[w_tx_first_idx];
                    end
                end
                ST_SHIFT: begin
                    if (clkgen_ctrl_tick) begin
                        if (!r_sck) begin
                            r_sck         <= 1'b1;
                            r_rx[w_rx_idx] <= spi_miso;
                        end else begin
                            r_sck <= 1'b0;
                            if (r_bit_cnt != 6'd0) begin
                                r_bit_cnt <= w_cnt_dec;
                                r_mosi    <= r_tx[w_tx_next_idx];
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (clkgen_ctrl_tick) begin
                        if (w_hold_last) begin
                            r_cs_n    <= 1'b1;
                            r_rd_en   <= 1'b1;
                            // Stale bits above the transfer length are masked off here.
                            r_rx_data <= r_rx & w_rx_mask;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 4'd1;
                        end
                    end
                end
                ST_DONE: begin
                    r_mosi <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign ctrl_reg_busy    = (r_state != ST_IDLE);
    assign ctrl_reg_rx_data = r_rx_data;
    assign ctrl_reg_rd_en   = r_rd_en;
    assign spi_sck          = r_sck;
    assign spi_mosi         = r_mosi;
    assign spi_cs_n         = r_cs_n;
    assign spi_oe           = r_oe;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Testbench for spi_master_ctrl: directed cases plus randomized transfers,
// checked every cycle against a tick-count model of a transfer.
module tb_spi_master_ctrl;

    localparam int H = 3;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        reg_ctrl_tran = 1'b0;
    logic [2:0]  reg_ctrl_bc = 3'd0;
    logic [63:0] reg_ctrl_tx_data = 64'd0;
    logic        reg_ctrl_oe = 1'b0;
    logic        clkgen_ctrl_tick = 1'b0;
    logic        spi_miso;
    logic        ctrl_reg_busy;
    logic [63:0] ctrl_reg_rx_data;
    logic        ctrl_reg_rd_en;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_cs_n;
    logic        spi_oe;

    // 0: loopback, 1: inverted loopback, 2: tied 0, 3: tied 1
    logic [1:0]  miso_mode = 2'd0;

    assign spi_miso = (miso_mode == 2'd0) ? spi_mosi :
                      (miso_mode == 2'd1) ? ~spi_mosi : miso_mode[0];

    spi_master_ctrl #(.HOLD_TICKS(H)) dut (
        .sys_clk          (sys_clk),
        .rst              (rst),
        .reg_ctrl_tran    (reg_ctrl_tran),
        .reg_ctrl_bc      (reg_ctrl_bc),
        .reg_ctrl_tx_data (reg_ctrl_tx_data),
        .reg_ctrl_oe      (reg_ctrl_oe),
        .clkgen_ctrl_tick (clkgen_ctrl_tick),
        .spi_miso         (spi_miso),
        .ctrl_reg_busy    (ctrl_reg_busy),
        .ctrl_reg_rx_data (ctrl_reg_rx_data),
        .ctrl_reg_rd_en   (ctrl_reg_rd_en),
        .spi_sck          (spi_sck),
        .spi_mosi         (spi_mosi),
        .spi_cs_n         (spi_cs_n),
        .spi_oe           (spi_oe)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- tick / oe stimulus ----------------
    int tick_div = 2;
    bit tick_en = 1'b1;
    bit tick_rand = 1'b0;
    bit oe_rand = 1'b0;
    int div_cnt = 0;

    initial begin
        forever begin
            @(posedge sys_clk);
            #1;
            if (oe_rand) reg_ctrl_oe = 1'($urandom_range(0, 1));
            if (!tick_en) begin
                clkgen_ctrl_tick = 1'b0;
            end else if (tick_rand) begin
                clkgen_ctrl_tick = 1'($urandom_range(0, 1));
            end else if (div_cnt >= tick_div - 1) begin
                clkgen_ctrl_tick = 1'b1;
                div_cnt = 0;
            end else begin
                clkgen_ctrl_tick = 1'b0;
                div_cnt++;
            end
        end
    end

    // ---------------- reference model ----------------
    // A transfer of n bits is described by the number of ticks t seen since it
    // started: tick 1 leaves setup, even ticks 2..2n raise SCK (bit (t-2)/2 is
    // sampled), odd ticks 3..2n+1 lower it, and H ticks later CS_n rises for
    // the single result cycle.
    function automatic logic [63:0] f_mask(input int n);
        return (n >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
    endfunction

    function automatic logic f_bit(input logic [63:0] tx, input int n, input int k);
`ifdef SPI_MASTER_LSB_FIRST_EN
        return tx[k];
`else
        return tx[n - 1 - k];
`endif
    endfunction

    function automatic logic [63:0] f_rx(input logic [63:0] tx, input int n, input logic [1:0] mode);
        case (mode)
            2'd0:    return tx & f_mask(n);
            2'd1:    return ~tx & f_mask(n);
            2'd2:    return 64'd0;
            default: return f_mask(n);
        endcase
    endfunction

    bit          m_valid = 1'b0;
    bit          m_active = 1'b0;
    bit          m_rd = 1'b0;
    bit          m_oe = 1'b0;
    int          m_t = 0;
    int          m_n = 8;
    logic [63:0] m_tx = 64'd0;
    logic [63:0] m_rx = 64'd0;
    logic [1:0]  m_mode = 2'd0;
    int          cyc = 0;

    // monitor observations used by the directed checks
    int          sck_rises = 0;
    int          sck_edges = 0;
    int          rd_cnt = 0;
    int          last_fall_cyc = 0;
    int          cs_rise_cyc = 0;
    logic [63:0] mosi_bits = 64'd0;
    logic        first_mosi = 1'b0;
    logic        prev_sck = 1'b0;
    logic        prev_cs = 1'b1;

    initial begin
        int   m_end;
        logic exp_sck;
        forever begin
            @(posedge sys_clk);
            cyc++;
            m_end = 2 * m_n + 1 + H;
            if (rst) begin
                m_active = 1'b0;
                m_t      = 0;
                m_rx     = 64'd0;
                m_rd     = 1'b0;
                m_oe     = 1'b0;
            end else begin
                m_oe = reg_ctrl_oe;
                m_rd = 1'b0;
                if (!m_active) begin
                    if (reg_ctrl_tran) begin
                        m_active = 1'b1;
                        m_t      = 0;
                        m_n      = 8 * (int'(reg_ctrl_bc) + 1);
                        m_tx     = reg_ctrl_tx_data;
                        m_mode   = miso_mode;
                    end
                end else if (m_t == m_end) begin
                    m_active = 1'b0;
                end else if (clkgen_ctrl_tick) begin
                    m_t++;
                    if (m_t == m_end) begin
                        m_rd = 1'b1;
                        m_rx = f_rx(m_tx, m_n, m_mode);
                    end
                end
            end
            m_valid = 1'b1;

            @(negedge sys_clk);
            m_end   = 2 * m_n + 1 + H;
            exp_sck = m_active && (m_t >= 2) && (m_t <= 2 * m_n) && (m_t % 2 == 0);
            if (m_valid) begin
                check("busy", {63'd0, ctrl_reg_busy}, {63'd0, m_active});
                check("cs_n", {63'd0, spi_cs_n}, {63'd0, !(m_active && (m_t < m_end))});
                check("sck", {63'd0, spi_sck}, {63'd0, exp_sck});
                check("rd_en", {63'd0, ctrl_reg_rd_en}, {63'd0, m_rd});
                check("rx_data", ctrl_reg_rx_data, m_rx);
                check("oe", {63'd0, spi_oe}, {63'd0, m_oe});
                if (!m_active)
                    check("mosi_idle", {63'd0, spi_mosi}, 64'd0);
                else if (exp_sck)
                    check("mosi_bit", {63'd0, spi_mosi}, {63'd0, f_bit(m_tx, m_n, (m_t - 2) / 2)});
            end

            if (spi_sck && !prev_sck) begin
                if (sck_rises == 0) first_mosi = spi_mosi;
                sck_rises++;
                sck_edges++;
                mosi_bits = {mosi_bits[62:0], spi_mosi};
            end
            if (!spi_sck && prev_sck) begin
                sck_edges++;
                last_fall_cyc = cyc;
            end
            if (spi_cs_n && !prev_cs) cs_rise_cyc = cyc;
            if (ctrl_reg_rd_en) rd_cnt++;
            prev_sck = spi_sck;
            prev_cs  = spi_cs_n;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clr_mon();
        sck_rises = 0;
        sck_edges = 0;
        rd_cnt    = 0;
        mosi_bits = 64'd0;
    endtask

    task automatic wait_busy(input logic lvl, input string name);
        for (int i = 0; i < 6000; i++) begin
            if (ctrl_reg_busy === lvl) break;
            @(posedge sys_clk);
            #1;
        end
        check(name, {63'd0, ctrl_reg_busy}, {63'd0, lvl});
    endtask

    task automatic start_xfer(input logic [2:0] bc, input logic [63:0] tx, input logic [1:0] mode);
        @(posedge sys_clk);
        #1;
        reg_ctrl_bc      = bc;
        reg_ctrl_tx_data = tx;
        miso_mode        = mode;
        reg_ctrl_tran    = 1'b1;
        @(posedge sys_clk);
        #1;
        wait_busy(1'b1, "busy_rise");
        reg_ctrl_tran    = 1'b0;
        // scribble over the request registers; the transfer must not notice
        reg_ctrl_bc      = 3'($urandom);
        reg_ctrl_tx_data = {$urandom, $urandom};
    endtask

    task automatic run_xfer(input logic [2:0] bc, input logic [63:0] tx, input logic [1:0] mode);
        start_xfer(bc, tx, mode);
        wait_busy(1'b0, "busy_fall");
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [63:0] tx;
        // reset state, with oe requested to show reset overrides it
        rst = 1'b1;
        reg_ctrl_oe = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_cs_n", {63'd0, spi_cs_n}, 64'd1);
        check("rst_sck", {63'd0, spi_sck}, 64'd0);
        check("rst_mosi", {63'd0, spi_mosi}, 64'd0);
        check("rst_oe", {63'd0, spi_oe}, 64'd0);
        check("rst_busy", {63'd0, ctrl_reg_busy}, 64'd0);
        check("rst_rd_en", {63'd0, ctrl_reg_rd_en}, 64'd0);
        check("rst_rx", ctrl_reg_rx_data, 64'd0);
        rst = 1'b0;
        reg_ctrl_oe = 1'b0;

        // one byte, loopback, tick every 2 clk
        tick_div = 2;
        clr_mon();
        run_xfer(3'd0, 64'h0000_0000_0000_00A5, 2'd0);
        check("a5_pulses", 64'(sck_rises), 64'd8);
        check("a5_mosi_seq", {56'd0, mosi_bits[7:0]}, 64'h0000_0000_0000_00A5);
        check("a5_rd_cnt", 64'(rd_cnt), 64'd1);
        check("a5_rx", ctrl_reg_rx_data, 64'h0000_0000_0000_00A5);

        // full 64-bit word, loopback
        clr_mon();
        run_xfer(3'd7, 64'h0123_4567_89AB_CDEF, 2'd0);
        check("w64_pulses", 64'(sck_rises), 64'd64);
        check("w64_rx", ctrl_reg_rx_data, 64'h0123_4567_89AB_CDEF);

        // two bytes with miso tied high; upper bits must read 0
        run_xfer(3'd1, 64'd0, 2'd3);
        check("tie1_rx", ctrl_reg_rx_data, 64'h0000_0000_0000_FFFF);

        // hold time with a slow tick, and first bit order
        tick_div = 4;
        clr_mon();
        run_xfer(3'd0, 64'h0000_0000_0000_0001, 2'd0);
        check("hold_clks", 64'(cs_rise_cyc - last_fall_cyc), 64'd12);
`ifdef SPI_MASTER_LSB_FIRST_EN
        check("first_bit", {63'd0, first_mosi}, 64'd1);
`else
        check("first_bit", {63'd0, first_mosi}, 64'd0);
`endif
        check("hold_rx", ctrl_reg_rx_data, 64'h0000_0000_0000_0001);

        // stalled clock generator, then resumed
        tick_div = 2;
        tick_en  = 1'b0;
        clr_mon();
        start_xfer(3'd2, 64'h0000_0000_00C3_5A96, 2'd0);
        repeat (50) @(posedge sys_clk);
        #1;
        check("stall_cs_n", {63'd0, spi_cs_n}, 64'd0);
        check("stall_busy", {63'd0, ctrl_reg_busy}, 64'd1);
        check("stall_sck", {63'd0, spi_sck}, 64'd0);
        tick_en = 1'b1;
        wait_busy(1'b0, "stall_done");
        check("stall_rd_cnt", 64'(rd_cnt), 64'd1);
        check("stall_rx", ctrl_reg_rx_data, 64'h0000_0000_00C3_5A96);

        // request left high across DONE starts a second transfer
        tick_div = 1;
        clr_mon();
        @(posedge sys_clk);
        #1;
        reg_ctrl_bc      = 3'd0;
        reg_ctrl_tx_data = 64'h0000_0000_0000_003C;
        miso_mode        = 2'd1;
        reg_ctrl_tran    = 1'b1;
        wait_busy(1'b1, "b2b_rise1");
        wait_busy(1'b0, "b2b_fall1");
        @(posedge sys_clk);
        #1;
        wait_busy(1'b1, "b2b_rise2");
        reg_ctrl_tran = 1'b0;
        wait_busy(1'b0, "b2b_fall2");
        check("b2b_rd_cnt", 64'(rd_cnt), 64'd2);
        check("b2b_rx", ctrl_reg_rx_data, 64'h0000_0000_0000_00C3);

        // reset after 10 SCK edges aborts with no strobe
        tick_div = 2;
        clr_mon();
        start_xfer(3'd3, 64'h0000_0000_DEAD_BEEF, 2'd3);
        for (int i = 0; i < 2000; i++) begin
            @(negedge sys_clk);
            #1;
            if (sck_edges >= 10) break;
        end
        check("abort_edges", 64'(sck_edges), 64'd10);
        rst = 1'b1;
        #1;
        check("abort_cs_n", {63'd0, spi_cs_n}, 64'd1);
        check("abort_busy", {63'd0, ctrl_reg_busy}, 64'd0);
        check("abort_sck", {63'd0, spi_sck}, 64'd0);
        check("abort_rx", ctrl_reg_rx_data, 64'd0);
        @(posedge sys_clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge sys_clk);
        #1;
        check("abort_rd_cnt", 64'(rd_cnt), 64'd0);

        // randomized transfers with random oe, tick patterns and miso modes
        oe_rand = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick_rand = ($urandom_range(0, 2) == 0);
            tick_div  = $urandom_range(1, 4);
            tx        = {$urandom, $urandom};
            run_xfer(3'($urandom_range(0, 7)), tx, 2'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 3)) @(posedge sys_clk);
        end
        oe_rand   = 1'b0;
        tick_rand = 1'b0;
        repeat (5) @(posedge sys_clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 SHALL have parameter HOLD_TICKS, default 1: ticks between the last SCK falling edge and CS_n deassertion (range 1..15).
REQ-002 SHALL have one clock and an asynchronous, active-high reset; the ports are listed below.
REQ-003 sys_clk  in  1  system clock; all flops on rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 reg_ctrl_tran  in  1  transfer request level from the register block; it is cleared by that block once ctrl_reg_busy is seen.
REQ-006 reg_ctrl_bc  in  3  byte count minus one; a transfer is bc+1 bytes, 8..64 bits.
REQ-007 reg_ctrl_tx_data  in  64  transmit data, right-aligned; bits [8*(bc+1)-1:0] are sent.
REQ-008 reg_ctrl_oe  in  1  pad output enable request.
REQ-009 clkgen_ctrl_tick  in  1  one-cycle pulse from the clock generator, one per SCK half-period.
REQ-010 spi_miso  in  1  serial input, already synchronised externally.
REQ-011 ctrl_reg_busy  out  1  transfer in progress.
REQ-012 ctrl_reg_rx_data  out  64  received data, right-aligned; unused upper bits are 0.
REQ-013 ctrl_reg_rd_en  out  1  one-cycle strobe marking ctrl_reg_rx_data valid.
REQ-014 spi_sck, spi_mosi, spi_cs_n, spi_oe  out  1 each  SPI pins; spi_oe is the pad enable.

Function
REQ-015 FSM SHALL have five states: IDLE, SETUP, SHIFT, HOLD, DONE.
REQ-016 IDLE: reg_ctrl_tran=1 SHALL, on the next edge, give: state SETUP, bc latched, tx_data latched into the shift register, bit counter=8*(bc+1)-1, spi_cs_n=0, and spi_mosi=first bit.
REQ-017 ctrl_reg_busy SHALL be 1 in SETUP, SHIFT, HOLD and DONE, and 0 in IDLE.
REQ-018 SETUP SHALL move to SHIFT on the first tick, with spi_sck still 0.
REQ-019 SHIFT, tick with spi_sck=0: spi_sck SHALL go to 1 and spi_miso SHALL be shifted into the rx register.
REQ-020 SHIFT, tick with spi_sck=1: spi_sck SHALL go to 0; if counter≠0, the next tx bit SHALL drive spi_mosi and the counter SHALL decrement; if counter=0, the state SHALL go to HOLD.
REQ-021 Mode SHALL be CPOL=0, CPHA=0; spi_sck SHALL idle at 0.
REQ-022 HOLD SHALL count HOLD_TICKS ticks, then enter DONE.
REQ-023 DONE SHALL last one sys_clk: spi_cs_n=1, ctrl_reg_rd_en=1, ctrl_reg_rx_data updated in the same cycle; then the state SHALL go to IDLE.
REQ-024 ctrl_reg_rx_data SHALL hold its value until the next DONE.
REQ-025 reg_ctrl_tran still high in the first IDLE cycle after DONE (register clear lag) SHALL NOT occur by protocol; if it is high, a new transfer SHALL start.
REQ-026 No ticks (clock generator disabled) SHALL stall the FSM in its current state with all outputs held.
REQ-027 Changes to reg_ctrl_bc or reg_ctrl_tx_data while busy SHALL be ignored, because the values are latched at start.
REQ-028 spi_oe SHALL equal reg_ctrl_oe registered one cycle later, independent of FSM state.
REQ-029 spi_mosi SHALL be 0 in IDLE.

Reset
REQ-030 rst=1 SHALL immediately force: state=IDLE, spi_cs_n=1, spi_sck=0, spi_mosi=0, spi_oe=0, ctrl_reg_busy=0, ctrl_reg_rd_en=0, ctrl_reg_rx_data=0, all counters 0.
REQ-031 Reset mid-transfer SHALL abort the transfer with no ctrl_reg_rd_en pulse; partial rx data SHALL be discarded.

Configuration
REQ-032 Macro SPI_MASTER_LSB_FIRST_EN SHALL select bit order.
REQ-033 With SPI_MASTER_LSB_FIRST_EN defined, tx_data[0] SHALL be sent first and the first received bit SHALL land in rx_data[0].
REQ-034 Without SPI_MASTER_LSB_FIRST_EN, bit 8*(bc+1)-1 SHALL be sent first and the last received bit SHALL land in rx_data[0] (MSB-first).

Verification
REQ-035 bc=0, tx=0x...00A5, miso looped to mosi, tick every 2 clk -> mosi sequence 1,0,1,0,0,1,0,1; 8 SCK pulses; rd_en once; rx_data=0x00000000000000A5.
REQ-036 bc=7, tx=0x0123456789ABCDEF, loopback -> 64 SCK pulses; rx_data=0x0123456789ABCDEF; busy high from the cycle after tran until the cycle after DONE.
REQ-037 bc=1, miso tied 1, tx=0 -> rx_data=0x000000000000FFFF; upper bits remain 0.
REQ-038 Tick held low after tran -> cs_n=0, busy=1, sck stays 0 indefinitely; restoring ticks completes the transfer normally.
REQ-039 rst pulsed after 10 SCK edges of a bc=3 transfer -> cs_n=1, busy=0, sck=0 at once; no rd_en; rx_data=0.
REQ-040 HOLD_TICKS=3, tick every 4 clk -> 12 clk from the last SCK fall to cs_n rise; LSB_FIRST_EN build with tx=0x01, bc=0 -> first mosi bit 1.
